// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD1,
    ST_RD2,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_ram_bridge_if.sv
// AHB-Lite slave-side bus signals for the RAM bridge.
interface ahb_ram_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Decodes HSIZE and the low address bits into RAM byte lanes and flags
// sizes/alignments the RAM port cannot serve.
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);

  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask    = 4'b1111;
        illegal = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_ram_bridge.sv
// AHB-Lite slave driving a word-wide RAM port with byte write enables.
//
// state   | meaning
// IDLE    | no data phase in progress
// WR      | write data phase, ram_we = lane mask, commits on closing edge
// RD      | zero-wait read data phase, HRDATA = ram_spo
// RD1     | registered read, wait state while ram_spo is captured
// RD2     | registered read data phase, HRDATA = capture register
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high
module ahb_ram_bridge
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int REG_RDATA  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_ram_bridge_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [31:0]           ram_d,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_spo
);

  state_e      state_q, state_d;
  logic [3:0]  mask_q;
  logic [3:0]  lane_mask;
  logic        lane_illegal;
  logic [31:0] hrdata_q;
  logic        hreadyout;
  logic        accept;
  logic        unused_bits;

  ahb_byte_lane_dec u_lane_dec (
    .hsize   (bus.HSIZE),
    .addr_lo (bus.HADDR[1:0]),
    .mask    (lane_mask),
    .illegal (lane_illegal)
  );

  assign hreadyout = !(state_q == ST_RD1 || state_q == ST_ERR1);
  // Gating on our own ready keeps ram_a stable if the bus ever misbehaves.
  assign accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY & hreadyout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= 4'b0000;
      ram_a    <= '0;
      hrdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ram_a  <= bus.HADDR[ADDR_WIDTH+1:2];
        mask_q <= lane_mask;
      end
      if (state_q == ST_RD1) hrdata_q <= ram_spo;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (accept) begin
      if (lane_illegal)       state_d = ST_ERR1;
      else if (bus.HWRITE)    state_d = ST_WR;
      else if (REG_RDATA != 0) state_d = ST_RD1;
      else                    state_d = ST_RD;
    end
    case (state_q)
      ST_RD1:  state_d = ST_RD2;
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase
  end

  assign ram_we        = (state_q == ST_WR) ? mask_q : 4'b0000;
  assign ram_d         = bus.HWDATA;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (REG_RDATA != 0) ? hrdata_q : ram_spo;

  assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// Bench for ahb_ram_bridge: zero-wait and registered-read instances, each
// with a behavioural byte-writable RAM.
module tb_ahb_ram_bridge;
  import ahb_pkg::*;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel0, sel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;

  ahb_ram_bridge_if bus0 ();
  ahb_ram_bridge_if bus1 ();

  assign bus0.HSEL   = sel0;
  assign bus0.HADDR  = haddr;
  assign bus0.HTRANS = htrans;
  assign bus0.HSIZE  = hsize;
  assign bus0.HWRITE = hwrite;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HSEL   = sel1;
  assign bus1.HADDR  = haddr;
  assign bus1.HTRANS = htrans;
  assign bus1.HSIZE  = hsize;
  assign bus1.HWRITE = hwrite;
  assign bus1.HWDATA = hwdata;
  assign bus1.HREADY = bus1.HREADYOUT;

  logic [AW-1:0] ram_a0, ram_a1;
  logic [31:0]   ram_d0, ram_d1, ram_spo0, ram_spo1;
  logic [3:0]    ram_we0, ram_we1;
  logic [31:0]   mem0 [0:(1<<AW)-1];
  logic [31:0]   mem1 [0:(1<<AW)-1];

  ahb_ram_bridge #(.ADDR_WIDTH(AW), .REG_RDATA(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .ram_a(ram_a0), .ram_d(ram_d0), .ram_we(ram_we0), .ram_spo(ram_spo0));

  ahb_ram_bridge #(.ADDR_WIDTH(AW), .REG_RDATA(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .ram_a(ram_a1), .ram_d(ram_d1), .ram_we(ram_we1), .ram_spo(ram_spo1));

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign ram_spo0 = mem0[ram_a0];
  assign ram_spo1 = mem1[ram_a1];
  always @(posedge clk) begin
    if (|ram_we0) mem0[ram_a0] <= merge(mem0[ram_a0], ram_d0, ram_we0);
    if (|ram_we1) mem1[ram_a1] <= merge(mem1[ram_a1], ram_d1, ram_we1);
  end

  typedef struct {
    logic          dut;
    logic          sel;
    logic [31:0]   addr;
    logic [1:0]    trans;
    logic [2:0]    size;
    logic          wr;
    logic [31:0]   wdata;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic          rdy;
    logic          resp;
    logic          chk_rd;
    logic [31:0]   rd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic d, input logic s, input logic [31:0] ad, input logic [1:0] tr,
                     input logic [2:0] sz, input logic w, input logic [31:0] wd,
                     input logic [3:0] we, input logic [AW-1:0] a, input logic rdy,
                     input logic resp, input logic chk, input logic [31:0] rd);
    vecs.push_back('{d, s, ad, tr, sz, w, wd, we, a, rdy, resp, chk, rd});
  endtask

  // Applies one bus cycle from vector i (at posedge+1), checks at posedge+4.
  task automatic run_row(input int i);
    vec_t v;
    v      = vecs[i];
    sel0   = v.sel & ~v.dut;
    sel1   = v.sel & v.dut;
    haddr  = v.addr;
    htrans = v.trans;
    hsize  = v.size;
    hwrite = v.wr;
    hwdata = v.wdata;
    #3;
    if (!v.dut) begin
      check($sformatf("r%0d_we", i),   {28'h0, ram_we0}, {28'h0, v.we});
      check($sformatf("r%0d_a", i),    {18'h0, ram_a0}, {18'h0, v.a});
      check($sformatf("r%0d_rdy", i),  {31'h0, bus0.HREADYOUT}, {31'h0, v.rdy});
      check($sformatf("r%0d_resp", i), {31'h0, bus0.HRESP}, {31'h0, v.resp});
      if (v.chk_rd) check($sformatf("r%0d_rdata", i), bus0.HRDATA, v.rd);
    end else begin
      check($sformatf("r%0d_we", i),   {28'h0, ram_we1}, {28'h0, v.we});
      check($sformatf("r%0d_a", i),    {18'h0, ram_a1}, {18'h0, v.a});
      check($sformatf("r%0d_rdy", i),  {31'h0, bus1.HREADYOUT}, {31'h0, v.rdy});
      check($sformatf("r%0d_resp", i), {31'h0, bus1.HRESP}, {31'h0, v.resp});
      if (v.chk_rd) check($sformatf("r%0d_rdata", i), bus1.HRDATA, v.rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [1:0] TI = HTRANS_IDLE;
  localparam logic [1:0] TB = HTRANS_BUSY;
  localparam logic [1:0] TN = HTRANS_NONSEQ;
  int n_a;

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      mem0[k] = 32'h0;
      mem1[k] = 32'h0;
    end
    rst = 1'b1;
    sel0 = 1'b0; sel1 = 1'b0; haddr = 32'h0; htrans = TI;
    hsize = 3'd0; hwrite = 1'b0; hwdata = 32'h0;

    //   dut sel addr         tr  sz   wr  wdata         we       a   rdy resp chk rd
    // zero-wait instance: each row's checks describe the data phase of the previous row
    row(0, 1, 32'h0000_0006, TN, 3'd0, 1, 32'h0,        4'b0000, 0,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0004, TN, 3'd2, 0, 32'h00AB_0000, 4'b0100, 1,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0010, TN, 3'd2, 1, 32'h0,        4'b0000, 1,  1, 0, 1, 32'h00AB_0000);
    row(0, 1, 32'h0000_0012, TN, 3'd1, 1, 32'h1122_3344, 4'b1111, 4,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0010, TN, 3'd2, 0, 32'hBEEF_0000, 4'b1100, 4,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0001, TN, 3'd1, 1, 32'h0,        4'b0000, 4,  1, 0, 1, 32'hBEEF_3344);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 0,  0, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 0,  1, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0040, TB, 3'd2, 1, 32'h0,        4'b0000, 0,  1, 0, 0, 32'h0);
    row(0, 0, 32'h0000_0044, TN, 3'd2, 1, 32'h5555_5555, 4'b0000, 0,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TN, 3'd2, 0, 32'h5555_5555, 4'b0000, 0,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0040, TN, 3'd2, 0, 32'h0,        4'b0000, 0,  1, 0, 1, 32'h0);
    row(0, 1, 32'h0000_0044, TN, 3'd2, 0, 32'h0,        4'b0000, 16, 1, 0, 1, 32'h0);
    row(0, 1, 32'h0000_0021, TN, 3'd0, 1, 32'h0,        4'b0000, 17, 1, 0, 1, 32'h0);
    row(0, 1, 32'h0000_0020, TN, 3'd2, 0, 32'h0000_CD00, 4'b0010, 8,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TN, 3'd3, 1, 32'h0,        4'b0000, 8,  1, 0, 1, 32'h0000_CD00);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 0,  0, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 0,  1, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0032, TN, 3'd2, 1, 32'h0,        4'b0000, 0,  1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 12, 0, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'hFFFF_FFFF, 4'b0000, 12, 1, 1, 0, 32'h0);
    row(0, 1, 32'h0000_0030, TN, 3'd2, 0, 32'h0,        4'b0000, 12, 1, 0, 0, 32'h0);
    row(0, 1, 32'h0000_0000, TI, 3'd0, 0, 32'h0,        4'b0000, 12, 1, 0, 1, 32'h0);
    n_a = vecs.size();
    // registered-read instance
    row(1, 1, 32'h0000_0010, TN, 3'd2, 1, 32'h0,        4'b0000, 0,  1, 0, 1, 32'h0);
    row(1, 1, 32'h0000_0012, TN, 3'd1, 1, 32'h1122_3344, 4'b1111, 4,  1, 0, 0, 32'h0);
    row(1, 1, 32'h0000_0010, TN, 3'd2, 0, 32'hBEEF_0000, 4'b1100, 4,  1, 0, 0, 32'h0);
    row(1, 1, 32'h0000_0000, TI, 3'd0, 0, 32'h0,        4'b0000, 4,  0, 0, 1, 32'h0);
    row(1, 1, 32'h0000_0000, TI, 3'd0, 0, 32'h0,        4'b0000, 4,  1, 0, 1, 32'hBEEF_3344);
    row(1, 1, 32'h0000_0000, TI, 3'd0, 0, 32'h0,        4'b0000, 4,  1, 0, 1, 32'hBEEF_3344);

    @(posedge clk); #1;
    check("rst_rdy0",  {31'h0, bus0.HREADYOUT}, 32'h1);
    check("rst_resp0", {31'h0, bus0.HRESP}, 32'h0);
    check("rst_we0",   {28'h0, ram_we0}, 32'h0);
    check("rst_a0",    {18'h0, ram_a0}, 32'h0);
    check("rst_rd1",   bus1.HRDATA, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < n_a; i++) run_row(i);

    // Reset asserted in the middle of a write data phase to word 2.
    sel0 = 1'b1; haddr = 32'h0000_0008; htrans = TN; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = TI; hwdata = 32'hDEAD_BEEF;
    #2;
    check("rstwr_we_before", {28'h0, ram_we0}, 32'hF);
    #1 rst = 1'b1;
    #1;
    check("rstwr_we_async", {28'h0, ram_we0}, 32'h0);
    check("rstwr_rdy",      {31'h0, bus0.HREADYOUT}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr_resp", {31'h0, bus0.HRESP}, 32'h0);
    haddr = 32'h0000_0008; htrans = TN; hsize = 3'd2; hwrite = 1'b0;
    @(posedge clk); #1;
    htrans = TI;
    #3;
    check("rstwr_a",     {18'h0, ram_a0}, 32'h2);
    check("rstwr_rdata", bus0.HRDATA, 32'h0);
    @(posedge clk); #1;

    for (int i = n_a; i < vecs.size(); i++) run_row(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ram_bridge.md
Name: ahb_ram_bridge

Overview:
- AHB-Lite slave that drives the SoC's word-wide memory port: word address, write data, 4-bit byte write-enable, combinational read data back.
- Sits between the bus matrix and the instruction/data RAM.
- Converts AHB address/data-phase pipelining into RAM writes and reads.
- Generates byte lanes from HSIZE/HADDR and returns two-cycle ERROR responses for illegal transfers.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width; ram_a = HADDR[ADDR_WIDTH+1:2].
- REG_RDATA, 0, 0 = HRDATA passes straight from ram_spo, zero wait; 1 = HRDATA registered, one wait state on reads.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HSIZE  in  3  0 byte, 1 half, 2 word, others illegal
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- ram_a  out  ADDR_WIDTH  RAM word address
- ram_d  out  32  RAM write data
- ram_we  out  4  RAM byte write-enables, bit n = byte lane n
- ram_spo  in  32  RAM combinational read data for ram_a

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, ram_we=0, ram_a=0, HRDATA register=0, byte-mask register=0.
- Accept: an address phase is accepted on a rising edge when HSEL & HTRANS[1] & HREADY. IDLE/BUSY or HSEL=0 transfers are not accepted and state returns to IDLE.
- Byte mask:
  - HSIZE=0: 4'b0001<<HADDR[1:0].
  - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011.
  - HSIZE=2: 4'b1111.
- Illegal transfer: HSIZE>2, or halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- Latched on accept: ram_a <= HADDR[ADDR_WIDTH+1:2], mask, direction, illegal flag. ram_a holds its value otherwise, including while idle.
- States:
  - IDLE: HREADYOUT=1, HRESP=0, ram_we=0.
  - WR: one cycle. ram_we=mask, ram_d=HWDATA (combinational), HREADYOUT=1. The write commits on the closing edge. Next state follows the accept rule.
  - RD (REG_RDATA=0): one cycle, HRDATA=ram_spo, HREADYOUT=1.
  - RD1 (REG_RDATA=1): HREADYOUT=0; HRDATA register <= ram_spo at the edge; go to RD2.
  - RD2 (REG_RDATA=1): HREADYOUT=1, HRDATA=register. Next state follows the accept rule.
  - ERR1: HREADYOUT=0, HRESP=1, ram_we=0; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the accept rule; a new transfer may be accepted here.
- Accepted illegal transfer → ERR1. No RAM write occurs for it; ram_a may update.
- Back-to-back: a write data phase (WR) overlaps the next address phase. No conflict, because ram_a switches to the new address only after the write edge.
- Read-after-write to the same word returns the new data with no stall.
- No new accept while HREADYOUT=0, since the bus holds HREADY low.
- ram_we is nonzero only in WR. ram_d=HWDATA at all times.
- HRDATA when REG_RDATA=0 is ram_spo at all times; it is valid only in RD.
- Reset mid-transfer: the pending write is dropped (ram_we goes 0 immediately, asynchronously) and the state returns to IDLE.

Decomposition:
- Shared package (ahb_pkg):
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE encodings BYTE/HALF/WORD.
  - HRESP OKAY/ERROR.
  - State enum {IDLE, WR, RD, RD1, RD2, ERR1, ERR2}.
- One natural sub-module, ahb_byte_lane_dec: combinational HSIZE + HADDR[1:0] → 4-bit mask plus illegal flag.

Test Plan:
- Byte write, then word read: write HSIZE=0 to HADDR=0x0000_0006 with HWDATA=0x00AB_0000. Required: ram_we=4'b0100, ram_a=1 in the data phase. Following word read at 0x4 returns 0x00AB_xxxx with the other lanes unchanged.
- Back-to-back writes then read:
  - Word write 0x11223344 @0x10, halfword write 0xBEEF_0000 @0x12, word read @0x10, all zero wait.
  - Required: ram_we sequence 1111, 1100.
  - HRDATA = 0xBEEF3344 with HREADYOUT held 1 throughout (REG_RDATA=0).
- Error response: halfword write @0x1 with HWDATA=0xFFFF_FFFF. Required: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), ram_we stays 0, memory unchanged.
- Registered read: REG_RDATA=1, read @0x10 after the writes above. Required: one cycle with HREADYOUT=0, then HRDATA=0xBEEF3344 with HREADYOUT=1.
- Idle and unselected transfers ignored: HTRANS=BUSY with HSEL=1, and HTRANS=NONSEQ with HSEL=0. Required: state stays IDLE, ram_we=0, ram_a unchanged.
- Reset during a write data phase: assert rst mid-cycle in WR. Required: ram_we drops to 0 asynchronously, the target word is unchanged, and after release HREADYOUT=1, HRESP=0.
